// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and constants for the program memory loader
package loader_pkg;

  localparam int unsigned DEPTH_WORDS            = 128;
  localparam int unsigned ADDR_WIDTH             = $clog2(DEPTH_WORDS);
  localparam logic [7:0]  SYNC_BYTE              = 8'hA5;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 100000;

  typedef enum logic [2:0] {
    SYNC,
    COUNT,
    DATA,
    CKSUM,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/program_memory_loader_if.sv
// rtl/program_memory_loader_if.sv - byte stream in and program memory write port out
interface program_memory_loader_if;
  import loader_pkg::*;

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles four stream bytes into one 32-bit word, first byte in [31:24]
module byte_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      shift_d[31 - 8*idx_q -: 8] = byte_data;
      idx_d                      = idx_q + 2'd1;
    end
  end

  // The completed word is presented in the same cycle as its last byte.
  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
  assign word_data  = shift_d;

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - boot loader filling the instruction store from a framed byte stream
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module program_memory_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  program_memory_loader_if.slave bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  loader_state_e         state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [TW-1:0]         idle_q, idle_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic        xfer, in_frame, timeout, last_word;
  logic        word_valid;
  logic [31:0] word_data;

  assign xfer      = bus.rx_valid && rx_ready_q;
  assign in_frame  = state_q inside {COUNT, DATA, CKSUM};
  assign timeout   = in_frame && !xfer && (idle_q == IDLE_LAST);
  assign last_word = word_valid && ((words_loaded_q + 1'b1) == count_q);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state_q != DATA),
    .byte_valid (xfer && (state_q == DATA)),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SYNC;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
      cpu_hold_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      words_loaded_q <= '0;
      count_q        <= '0;
      idle_q         <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      words_loaded_q <= words_loaded_d;
      count_q        <= count_d;
      idle_q         <= idle_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:  if (xfer && (bus.rx_data == SYNC_BYTE)) state_d = COUNT;
      COUNT: if (xfer) state_d = ((bus.rx_data == 8'd0) || (bus.rx_data > 8'(DEPTH_WORDS))) ? ERROR : DATA;
`ifdef LOADER_CHECKSUM_EN
      DATA:  if (last_word) state_d = CKSUM;
      CKSUM: if (xfer) state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
`else
      DATA:  if (last_word) state_d = DONE;
`endif
      DONE:  if (start) state_d = SYNC;
      ERROR: if (start) state_d = SYNC;
      default: state_d = ERROR;
    endcase
    if (timeout) state_d = ERROR;
  end

  // Status outputs are decoded from the next state so they change together with it.
  always_comb begin
    rx_ready_d     = state_d inside {SYNC, COUNT, DATA, CKSUM};
    cpu_hold_d     = (state_d != DONE);
    load_done_d    = (state_d == DONE);
    load_error_d   = (state_d == ERROR);
    mem_we_d       = word_valid;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q;
    count_d        = count_q;
    idle_d         = (in_frame && !xfer) ? idle_q + 1'b1 : '0;
    if (word_valid) begin
      mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
      mem_wdata_d    = word_data;
      words_loaded_d = words_loaded_q + 1'b1;
    end
    if (state_d == SYNC) words_loaded_d = '0;
    if ((state_q == COUNT) && xfer) count_d = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
    xor_d = xor_q;
    if (state_q == SYNC) xor_d = 8'd0;
    else if ((state_q == DATA) && xfer) xor_d = xor_q ^ bus.rx_data;
`endif
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign load_done     = load_done_q;
  assign load_error    = load_error_q;
  assign words_loaded  = words_loaded_q;

endmodule
